// File: rtl/bp_update_sched_if.sv
// ============================================================================
//  bp_update_sched_if
//  Bundle between the EXU, the update scheduler and branch_prediction.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface bp_update_sched_if #(
    parameter int CNT_W = 32
);
    logic             res_valid_i;
    logic             res_ready_o;
    logic [31:0]      res_pc_i;
    logic [31:0]      res_target_i;
    logic             res_taken_i;
    logic             res_call_i;
    logic             res_ret_i;
    logic             res_jmp_i;
    logic             res_mispredict_i;
    logic             stall_i;
    logic             branch_request_o;
    logic [31:0]      branch_source_o;
    logic [31:0]      branch_target_o;
    logic             branch_is_taken_o;
    logic             branch_is_call_o;
    logic             branch_is_ret_o;
    logic             branch_is_jmp_o;
    logic             branch_mispredict_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] perf_branch_cnt_o;
    logic [CNT_W-1:0] perf_mispred_cnt_o;

    modport master (
        output res_valid_i, res_pc_i, res_target_i, res_taken_i, res_call_i,
               res_ret_i, res_jmp_i, res_mispredict_i, stall_i,
        input  res_ready_o, branch_request_o, branch_source_o, branch_target_o,
               branch_is_taken_o, branch_is_call_o, branch_is_ret_o,
               branch_is_jmp_o, branch_mispredict_o, redirect_valid_o,
               redirect_pc_o, perf_branch_cnt_o, perf_mispred_cnt_o
    );

    modport slave (
        input  res_valid_i, res_pc_i, res_target_i, res_taken_i, res_call_i,
               res_ret_i, res_jmp_i, res_mispredict_i, stall_i,
        output res_ready_o, branch_request_o, branch_source_o, branch_target_o,
               branch_is_taken_o, branch_is_call_o, branch_is_ret_o,
               branch_is_jmp_o, branch_mispredict_o, redirect_valid_o,
               redirect_pc_o, perf_branch_cnt_o, perf_mispred_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_update_sched.sv
// ============================================================================
//  bp_update_sched
//  In-order FIFO of resolved branches feeding branch_prediction, with
//  mispredict redirect/ordering and saturating perf counters.
//  Rev 1.0
// ============================================================================
`default_nettype none

module bp_update_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    bp_update_sched_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      tgt_mem  [DEPTH];
    // {taken, call, ret, jmp, mispredict}
    logic [4:0]       flag_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    logic             ready, push, pop, head_mis;
    logic             request;
    logic [31:0]      source, target;
    logic [4:0]       flags;
    logic             redir_valid;
    logic [31:0]      redir_pc;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    assign ready    = (count < FULL_CNT) && (state != RECOVER);
    assign push     = bus.res_valid_i && ready;
    assign pop      = (count != '0) && !bus.stall_i;
    assign head_mis = flag_mem[rd_ptr][0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.res_pc_i;
            tgt_mem[wr_ptr]  <= bus.res_target_i;
            flag_mem[wr_ptr] <= {bus.res_taken_i, bus.res_call_i, bus.res_ret_i,
                                 bus.res_jmp_i, bus.res_mispredict_i};
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            request     <= 1'b0;
            source      <= '0;
            target      <= '0;
            flags       <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state       <= state_nx;
            request     <= pop;
            redir_valid <= push && bus.res_mispredict_i;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (bus.res_mispredict_i)
                    redir_pc <= bus.res_taken_i ? bus.res_target_i
                                                : bus.res_pc_i + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                source <= pc_mem[rd_ptr];
                target <= tgt_mem[rd_ptr];
                flags  <= flag_mem[rd_ptr];
                if (branch_cnt != '1)
                    branch_cnt <= branch_cnt + 1'b1;
                if (head_mis && (mispred_cnt != '1))
                    mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

    // Ready is low in RECOVER, so the mispredict entry is always the last one queued.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (push) state_nx = RUN;
            RUN:     if (pop && (count == ONE_CNT) && !push) state_nx = IDLE;
            RECOVER: if (pop && head_mis)
                         state_nx = (count == ONE_CNT) ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
        if (push && bus.res_mispredict_i)
            state_nx = RECOVER;
    end

    assign bus.res_ready_o         = ready;
    assign bus.branch_request_o    = request;
    assign bus.branch_source_o     = source;
    assign bus.branch_target_o     = target;
    assign bus.branch_is_taken_o   = flags[4];
    assign bus.branch_is_call_o    = flags[3];
    assign bus.branch_is_ret_o     = flags[2];
    assign bus.branch_is_jmp_o     = flags[1];
    assign bus.branch_mispredict_o = flags[0];
    assign bus.redirect_valid_o    = redir_valid;
    assign bus.redirect_pc_o       = redir_pc;
    assign bus.perf_branch_cnt_o   = branch_cnt;
    assign bus.perf_mispred_cnt_o  = mispred_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bp_update_sched.sv
// ============================================================================
//  tb_bp_update_sched
//  Directed self-checking bench for bp_update_sched (DEPTH=4, CNT_W=4).
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_bp_update_sched;
    logic clk;
    logic n_rst;
    int   errors;
    int   checks;

    bp_update_sched_if #(.CNT_W(4)) bif ();

    bp_update_sched #(.DEPTH(4), .CNT_W(4)) dut (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_one(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic taken, input logic call, input logic ret,
                            input logic jmp, input logic mis);
        bif.res_valid_i      = 1'b1;
        bif.res_pc_i         = pc;
        bif.res_target_i     = tgt;
        bif.res_taken_i      = taken;
        bif.res_call_i       = call;
        bif.res_ret_i        = ret;
        bif.res_jmp_i        = jmp;
        bif.res_mispredict_i = mis;
        @(posedge clk);
        @(negedge clk);
        bif.res_valid_i      = 1'b0;
        bif.res_mispredict_i = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bif.branch_request_o); end
        checks++; if (bif.branch_source_o !== 32'h0) begin errors++; $display("FAIL rst_src: got %h want 0", bif.branch_source_o); end
        checks++; if (bif.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL rst_redir: got %b want 0", bif.redirect_valid_o); end
        checks++; if (bif.perf_branch_cnt_o !== 4'h0) begin errors++; $display("FAIL rst_perf: got %h want 0", bif.perf_branch_cnt_o); end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bif.res_ready_o); end
    endtask

    task automatic test_single;
        push_one(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bif.branch_request_o); end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bif.branch_request_o); end
        checks++; if (bif.branch_source_o !== 32'h100) begin errors++; $display("FAIL single_src: got %h want 100", bif.branch_source_o); end
        checks++; if (bif.branch_target_o !== 32'h200) begin errors++; $display("FAIL single_tgt: got %h want 200", bif.branch_target_o); end
        checks++; if (bif.branch_is_taken_o !== 1'b1) begin errors++; $display("FAIL single_taken: got %b want 1", bif.branch_is_taken_o); end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL single_late: got %b want 0", bif.branch_request_o); end
        checks++; if (bif.branch_source_o !== 32'h100) begin errors++; $display("FAIL single_hold: got %h want 100", bif.branch_source_o); end
        checks++; if (bif.perf_branch_cnt_o !== 4'h1) begin errors++; $display("FAIL single_perf: got %h want 1", bif.perf_branch_cnt_o); end
    endtask

    task automatic test_reset_mid;
        bif.stall_i = 1'b1;
        for (int i = 0; i < 3; i++)
            push_one(32'h700 + 32'(i), 32'h800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready3: got %b want 1", bif.res_ready_o); end
        n_rst = 1'b0;
        #1;
        checks++; if (bif.branch_source_o !== 32'h0) begin errors++; $display("FAIL mid_src: got %h want 0", bif.branch_source_o); end
        checks++; if (bif.branch_target_o !== 32'h0) begin errors++; $display("FAIL mid_tgt: got %h want 0", bif.branch_target_o); end
        checks++; if (bif.branch_is_taken_o !== 1'b0) begin errors++; $display("FAIL mid_taken: got %b want 0", bif.branch_is_taken_o); end
        checks++; if (bif.perf_branch_cnt_o !== 4'h0) begin errors++; $display("FAIL mid_perf: got %h want 0", bif.perf_branch_cnt_o); end
        @(negedge clk);
        n_rst = 1'b1;
        bif.stall_i = 1'b0;
        @(negedge clk);
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bif.res_ready_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL mid_empty%0d: got %b want 0", i, bif.branch_request_o); end
        end
    endtask

    task automatic test_full_stall;
        bif.stall_i = 1'b1;
        for (int i = 0; i < 4; i++)
            push_one(32'h1000 + 32'(16*i), 32'h2000 + 32'(i), 1'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bif.res_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bif.res_ready_o); end
        bif.res_valid_i = 1'b1;
        bif.res_pc_i    = 32'hDEAD;
        bif.stall_i     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bif.res_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            checks++; if (bif.branch_request_o !== 1'b1) begin errors++; $display("FAIL full_req%0d: got %b want 1", i, bif.branch_request_o); end
            checks++; if (bif.branch_source_o !== 32'h1000 + 32'(16*i)) begin errors++; $display("FAIL full_src%0d: got %h want %h", i, bif.branch_source_o, 32'h1000 + 32'(16*i)); end
            checks++; if (bif.branch_is_taken_o !== 1'(i)) begin errors++; $display("FAIL full_taken%0d: got %b want %b", i, bif.branch_is_taken_o, 1'(i)); end
        end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL full_drop: got %b want 0", bif.branch_request_o); end
        checks++; if (bif.perf_branch_cnt_o !== 4'h4) begin errors++; $display("FAIL full_perf: got %h want 4", bif.perf_branch_cnt_o); end
    endtask

    task automatic test_mispredict;
        push_one(32'h10, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL mp_ready0: got %b want 1", bif.res_ready_o); end
        push_one(32'h20, 32'h90, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (bif.branch_source_o !== 32'h10) begin errors++; $display("FAIL mp_srcA: got %h want 10", bif.branch_source_o); end
        checks++; if (bif.branch_is_call_o !== 1'b1) begin errors++; $display("FAIL mp_callA: got %b want 1", bif.branch_is_call_o); end
        push_one(32'h40, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (bif.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL mp_redir: got %b want 1", bif.redirect_valid_o); end
        checks++; if (bif.redirect_pc_o !== 32'h44) begin errors++; $display("FAIL mp_redir_pc: got %h want 44", bif.redirect_pc_o); end
        checks++; if (bif.res_ready_o !== 1'b0) begin errors++; $display("FAIL mp_ready_low: got %b want 0", bif.res_ready_o); end
        checks++; if (bif.branch_source_o !== 32'h20) begin errors++; $display("FAIL mp_srcB: got %h want 20", bif.branch_source_o); end
        checks++; if (bif.branch_is_ret_o !== 1'b1) begin errors++; $display("FAIL mp_retB: got %b want 1", bif.branch_is_ret_o); end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b1) begin errors++; $display("FAIL mp_reqM: got %b want 1", bif.branch_request_o); end
        checks++; if (bif.branch_source_o !== 32'h40) begin errors++; $display("FAIL mp_srcM: got %h want 40", bif.branch_source_o); end
        checks++; if (bif.branch_mispredict_o !== 1'b1) begin errors++; $display("FAIL mp_misM: got %b want 1", bif.branch_mispredict_o); end
        checks++; if (bif.branch_is_jmp_o !== 1'b1) begin errors++; $display("FAIL mp_jmpM: got %b want 1", bif.branch_is_jmp_o); end
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL mp_ready_back: got %b want 1", bif.res_ready_o); end
        checks++; if (bif.redirect_valid_o !== 1'b0) begin errors++; $display("FAIL mp_redir_once: got %b want 0", bif.redirect_valid_o); end
        checks++; if (bif.perf_branch_cnt_o !== 4'h7) begin errors++; $display("FAIL mp_perf: got %h want 7", bif.perf_branch_cnt_o); end
        checks++; if (bif.perf_mispred_cnt_o !== 4'h1) begin errors++; $display("FAIL mp_mperf: got %h want 1", bif.perf_mispred_cnt_o); end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL mp_idle: got %b want 0", bif.branch_request_o); end
    endtask

    task automatic test_back_to_back;
        bif.stall_i = 1'b1;
        push_one(32'h3000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_one(32'h3004, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bif.stall_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bif.res_valid_i = 1'b1;
            bif.res_pc_i    = 32'h3000 + 32'(4*(k+2));
            @(posedge clk);
            @(negedge clk);
            checks++; if (bif.branch_source_o !== 32'h3000 + 32'(4*k) || bif.branch_request_o !== 1'b1) begin errors++; $display("FAIL b2b_src%0d: got %h/%b want %h/1", k, bif.branch_source_o, bif.branch_request_o, 32'h3000 + 32'(4*k)); end
            checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", k, bif.res_ready_o); end
        end
        bif.res_valid_i = 1'b0;
        for (int k = 10; k < 12; k++) begin
            @(negedge clk);
            checks++; if (bif.branch_source_o !== 32'h3000 + 32'(4*k) || bif.branch_request_o !== 1'b1) begin errors++; $display("FAIL b2b_drain%0d: got %h/%b want %h/1", k, bif.branch_source_o, bif.branch_request_o, 32'h3000 + 32'(4*k)); end
        end
        @(negedge clk);
        checks++; if (bif.branch_request_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bif.branch_request_o); end
    endtask

    task automatic test_counters;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            push_one(32'h500 + 32'(4*i), 32'h900, 1'(i), 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 0) begin
                checks++; if (bif.redirect_pc_o !== 32'h504) begin errors++; $display("FAIL cnt_redir_nt: got %h want 504", bif.redirect_pc_o); end
            end
            if (i == 1) begin
                checks++; if (bif.redirect_pc_o !== 32'h900) begin errors++; $display("FAIL cnt_redir_t: got %h want 900", bif.redirect_pc_o); end
            end
            @(negedge clk);
            if (i == 13) begin
                checks++; if (bif.perf_branch_cnt_o !== 4'hE) begin errors++; $display("FAIL cnt_14: got %h want e", bif.perf_branch_cnt_o); end
            end
            if (i == 14) begin
                checks++; if (bif.perf_mispred_cnt_o !== 4'hF) begin errors++; $display("FAIL cnt_15: got %h want f", bif.perf_mispred_cnt_o); end
            end
        end
        checks++; if (bif.perf_branch_cnt_o !== 4'hF) begin errors++; $display("FAIL cnt_sat: got %h want f", bif.perf_branch_cnt_o); end
        checks++; if (bif.perf_mispred_cnt_o !== 4'hF) begin errors++; $display("FAIL cnt_msat: got %h want f", bif.perf_mispred_cnt_o); end
        checks++; if (bif.res_ready_o !== 1'b1) begin errors++; $display("FAIL cnt_ready: got %b want 1", bif.res_ready_o); end
    endtask

    initial begin
        errors               = 0;
        checks               = 0;
        n_rst                = 1'b0;
        bif.res_valid_i      = 1'b0;
        bif.res_pc_i         = '0;
        bif.res_target_i     = '0;
        bif.res_taken_i      = 1'b0;
        bif.res_call_i       = 1'b0;
        bif.res_ret_i        = 1'b0;
        bif.res_jmp_i        = 1'b0;
        bif.res_mispredict_i = 1'b0;
        bif.stall_i          = 1'b0;
        test_reset;
        test_single;
        test_reset_mid;
        test_full_stall;
        test_mispredict;
        test_back_to_back;
        test_counters;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
